// File: rtl/key_poll_master_if.sv
// Avalon-MM read bus between the key poll master and the key PIO slave.
// The master drives the request; the slave answers with a stall and registered read data.
interface key_poll_master_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/key_poll_master.sv
// Avalon-MM read master that periodically polls a key PIO data register,
// debounces the sampled key vector and emits press/release strobes.
// Optional macro KEY_POLL_IRQ_EN adds an irq output set by any key press
// and cleared by irq_ack.
module key_poll_master #(
  parameter int KEY_W        = 2,
  parameter int POLL_DIV     = 50000,
  parameter int STABLE_CNT   = 4,
  parameter int READ_LATENCY = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  key_poll_master_if.master    avm,
  output logic [KEY_W-1:0]     key_state,
  output logic [KEY_W-1:0]     key_press,
  output logic [KEY_W-1:0]     key_release,
  output logic                 sample_valid
`ifdef KEY_POLL_IRQ_EN
  ,
  output logic                 irq,
  input  logic                 irq_ack
`endif
);

  localparam int TIMER_W = $clog2(POLL_DIV);
  localparam int CNT_W   = $clog2(STABLE_CNT + 1);
  localparam int LAT_W   = $clog2(READ_LATENCY + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(STABLE_CNT);
  localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LAT  = 2'd2,
    UPD  = 2'd3
  } state_t;

  state_t           state;
  logic [TIMER_W-1:0] timer;
  logic [LAT_W-1:0]   lat_cnt;
  logic [CNT_W-1:0]   stable_cnt;
  logic [KEY_W-1:0]   sample;
  logic [KEY_W-1:0]   last_sample;
  logic [KEY_W-1:0]   raw_keys;
  logic [CNT_W-1:0]   next_cnt;
  logic               commit;
  logic               unused_readdata;

  // The key register always lives at word address 0.
  assign avm.avm_address = 2'b00;

  // Only the low KEY_W bits carry key inputs.
  assign raw_keys        = avm.avm_readdata[KEY_W-1:0];
  assign unused_readdata = ^avm.avm_readdata[31:KEY_W];

  // Debounce update evaluated in UPD: restart the run on a new value,
  // otherwise extend it (saturating); commit once the run is long enough
  // and the sampled value differs from the committed state.
  always_comb begin
    next_cnt = stable_cnt;
    if (sample != last_sample) begin
      next_cnt = CNT_W'(1);
    end else if (stable_cnt != CNT_FULL) begin
      next_cnt = stable_cnt + CNT_W'(1);
    end
    commit = (next_cnt == CNT_FULL) && (sample != key_state);
  end

  // Poll FSM with debounce state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      timer        <= '0;
      lat_cnt      <= '0;
      stable_cnt   <= '0;
      sample       <= '0;
      last_sample  <= '0;
      key_state    <= '0;
      key_press    <= '0;
      key_release  <= '0;
      sample_valid <= 1'b0;
      avm.avm_read <= 1'b0;
    end else begin
      key_press    <= '0;
      key_release  <= '0;
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            if (timer == TIMER_LAST) begin
              timer        <= '0;
              avm.avm_read <= 1'b1;
              state        <= REQ;
            end else begin
              timer <= timer + TIMER_W'(1);
            end
          end
        end
        REQ: begin
          if (!avm.avm_waitrequest) begin
            avm.avm_read <= 1'b0;
            lat_cnt      <= '0;
            state        <= LAT;
          end
        end
        LAT: begin
          if (lat_cnt == LAT_LAST) begin
            sample       <= (ACTIVE_LOW != 0) ? ~raw_keys : raw_keys;
            sample_valid <= 1'b1;
            state        <= UPD;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        UPD: begin
          last_sample <= sample;
          stable_cnt  <= next_cnt;
          if (commit) begin
            key_state   <= sample;
            key_press   <= sample & ~key_state;
            key_release <= ~sample & key_state;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEY_POLL_IRQ_EN
  // Sticky interrupt: a press sets it, an acknowledge clears it, set wins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (|key_press) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule
